axi2lbus_burst_bridge: RTL
==========================

// Module: axi2lbus_burst_bridge
// PURPOSE
//  Local lbus to/from AXI3 master bridge with INCR bursts of 1..MaxBlen beats. Issues AW and W
//  concurrently, streams read beats through a registered skid buffer. Single transaction in flight.
//  Sits between lbus masters (DMA, SDRAM test engine) and the PS/PL AXI3 slave port.
// PARAMETERS
//  AddrW    32  byte address width
//  DataW    32  data width; power of 2, 8..1024
//  IdW      2   lbus requester id width
//  AxiIdW   4   AXI id width; AxiId driven on all AXI id outputs
//  AxiId    0   constant AXI id
//  MaxBlen  16  max beats per request; 1..16 (AXI3 limit)
//  StrbW    DataW/8 (derived); BlenW = $clog2(MaxBlen)+1 (derived)
// PORTS
//  clk  in 1  clock;  reset  in 1  synchronous, active-high
//  bus_req in 1 request; bus_we in 1 1=write; bus_id in IdW; bus_addr in AddrW; bus_blen in BlenW beats-1
//  bus_acko out 1 request accepted (1-cycle pulse); bus_busyo out 1 transaction in flight
//  bus_wdata in DataW; bus_wstrb in StrbW; bus_wvalid in 1; bus_wreadyo out 1  write beat stream
//  bus_rdatao out DataW; bus_rlasto out 1; bus_rvalido out 1; bus_rready in 1  read beat stream
//  bus_ido out IdW id of current txn; bus_doneo out 1 write/read completion pulse
//  axi_aw{ido,addro,leno,sizeo,bursto,valido}/axi_awready; axi_w{datao,strbo,lasto,valido}/axi_wready
//  axi_bvalid in, axi_bid in, axi_breadyo out; axi_ar{ido,addro,leno,sizeo,bursto,valido}/axi_arready
//  axi_rdata in, axi_rlast in, axi_rid in, axi_rvalid in, axi_rreadyo out
//  (axi_bresp/axi_rresp in, bus_erro out: only with AXI2LBUS_RESP_ERR_EN)
// BEHAVIOUR
//  Reset: state IDLE; all valid/ready/ack/done/busy outputs 0; rdata/id registers 0; skid empty.
//  Accept: IDLE && bus_req -> latch id/addr/blen/we, bus_acko=1 same cycle, busyo=1 next cycle.
//  States: IDLE -> RD_AR -> RD_DATA -> RD_DONE -> IDLE ;  IDLE -> WR -> WR_RESP -> IDLE.
//  RD_AR: arvalid=1, arlen=blen, arsize from DataW, burst INCR; arready -> RD_DATA.
//  RD_DATA: rreadyo = skid not full; beats pushed to skid; rlast accepted -> RD_DONE.
//  RD_DONE: wait skid empty; bus_doneo=1 one cycle; -> IDLE. bus_rlasto marks last beat.
//  Read beat count != blen+1 at rlast: simulation assertion; rlast still terminates.
//  WR: awvalid until awready (aw_done flag); wvalid=bus_wvalid, bus_wreadyo=axi_wready, in parallel.
//  Beat counter counts W handshakes; wlasto=1 when count==blen. Leave WR when aw_done && last W done
//  (both may complete same cycle) -> WR_RESP: breadyo=1; bvalid -> doneo=1, IDLE.
//  bus_wvalid outside WR ignored (bus_wreadyo=0). bus_req while busy ignored (no ack).
//  Back-to-back: new req accepted the cycle after doneo (in IDLE); no combinational ack->done path.
//  4KB: addr + (blen+1)*StrbW must not cross 4KB; simulation assertion; bridge does not split.
//  Unaligned addr passed through unchanged; strobes are the requester's responsibility.
//  bid/rid != AxiId: simulation assertion only. Reset mid-txn: abort to IDLE, drop valids.
// CONFIGURATION
//  AXI2LBUS_RESP_ERR_EN defined: adds axi_bresp/axi_rresp inputs and bus_erro output; bus_erro
//  sticky per txn (SLVERR/DECERR on any beat or B), valid with bus_doneo, cleared on next accept.
//  Undefined: ports absent, responses ignored, behaviour otherwise identical.
// STRUCTURE
//  Shared package (axi.svh): axi3_size_t, axi3_bst_t, axi3_resp_t, size decode function from
//  DataW; state enum local. Sub-module lbus_skid_buf (2-entry, DataW+1 wide: data+last,
//  valid/ready both sides, fully registered outputs) for read return path.
// TESTING
//  Read blen=0 addr 0x100, slave returns 0xDEADBEEF rlast -> one rvalido beat, rlasto=1, doneo.
//  Read blen=15, bus_rready toggles 1/0 -> 16 beats in order, no loss, rreadyo drops when skid full.
//  Write blen=3, awready delayed 5 cycles, wready=1 -> 4 W beats before AW, wlast on beat 4, doneo after B.
//  Write blen=0, AW and W handshake same cycle -> WR_RESP next cycle; bvalid held 3 cycles later -> done.
//  bus_req held during busy -> single ack; second req acked cycle after doneo.
//  With AXI2LBUS_RESP_ERR_EN: rresp=SLVERR on beat 2 of 4 -> bus_erro=1 at doneo, 0 after next accept.

Source files
------------

// File: rtl/axi2lbus_burst_bridge_pkg.sv
// Shared AXI3 types and helpers for the lbus-to-AXI3 burst bridge.
package axi2lbus_burst_bridge_pkg;

  typedef enum logic [2:0] {
    SIZE_1   = 3'd0,
    SIZE_2   = 3'd1,
    SIZE_4   = 3'd2,
    SIZE_8   = 3'd3,
    SIZE_16  = 3'd4,
    SIZE_32  = 3'd5,
    SIZE_64  = 3'd6,
    SIZE_128 = 3'd7
  } axi3_size_t;

  typedef enum logic [1:0] {
    BST_FIXED = 2'd0,
    BST_INCR  = 2'd1,
    BST_WRAP  = 2'd2,
    BST_RSVD  = 2'd3
  } axi3_bst_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } axi3_resp_t;

  function automatic axi3_size_t size_from_width(input int data_w);
    axi3_size_t size_v;
    case (data_w)
      8:       size_v = SIZE_1;
      16:      size_v = SIZE_2;
      32:      size_v = SIZE_4;
      64:      size_v = SIZE_8;
      128:     size_v = SIZE_16;
      256:     size_v = SIZE_32;
      512:     size_v = SIZE_64;
      1024:    size_v = SIZE_128;
      default: size_v = SIZE_4;
    endcase
    return size_v;
  endfunction

  // SLVERR and DECERR both have the upper response bit set.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (axi3_resp_t'(resp) == RESP_SLVERR) || (axi3_resp_t'(resp) == RESP_DECERR);
  endfunction

endpackage

// File: rtl/axi2lbus_burst_bridge_chk.sv
// Simulation checks for the bridge: 4KB crossing, read beat count and AXI id echo.
module axi2lbus_burst_bridge_chk #(
  parameter int BlenW  = 5,
  parameter int StrbW  = 4,
  parameter int AxiIdW = 4,
  parameter int AxiId  = 0
) (
  input logic              clk,
  input logic              reset,
  input logic              accept,
  input logic [11:0]       addr_lo,
  input logic [BlenW-1:0]  req_blen,
  input logic [BlenW-1:0]  blen,
  input logic [BlenW-1:0]  beat_cnt,
  input logic              r_hs,
  input logic              r_last,
  input logic [AxiIdW-1:0] rid,
  input logic              b_hs,
  input logic [AxiIdW-1:0] bid
);

  logic [31:0] end_s;

  assign end_s = 32'(addr_lo) + (32'(req_blen) + 32'd1) * 32'(StrbW);

  a_no_4kb_cross: assert property (@(posedge clk) disable iff (reset) accept |-> (end_s <= 32'd4096))
    else $error("burst crosses a 4KB boundary");

  a_rd_beat_count: assert property (@(posedge clk) disable iff (reset) (r_hs && r_last) |-> (beat_cnt == blen))
    else $error("read burst length does not match request");

  a_rid: assert property (@(posedge clk) disable iff (reset) r_hs |-> (rid == AxiIdW'(AxiId)))
    else $error("unexpected rid");

  a_bid: assert property (@(posedge clk) disable iff (reset) b_hs |-> (bid == AxiIdW'(AxiId)))
    else $error("unexpected bid");

endmodule

// File: rtl/axi2lbus_burst_bridge_skid.sv
// Two-entry skid buffer for the read return path; all outputs come straight from registers.
module lbus_skid_buf #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         empty
);

  logic [W-1:0] out_data_r;
  logic [W-1:0] skid_data_r;
  logic         out_valid_r;
  logic         skid_valid_r;
  logic         push_s;
  logic         pop_s;

  assign push_s    = in_valid && !skid_valid_r;
  assign pop_s     = out_valid_r && out_ready;
  assign in_ready  = !skid_valid_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign empty     = !out_valid_r && !skid_valid_r;

  // Output stage refills from the skid slot first so beat order is kept.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_r   <= '0;
      skid_data_r  <= '0;
      out_valid_r  <= 1'b0;
      skid_valid_r <= 1'b0;
    end else if (!out_valid_r || pop_s) begin
      if (skid_valid_r) begin
        out_data_r   <= skid_data_r;
        out_valid_r  <= 1'b1;
        skid_valid_r <= 1'b0;
      end else begin
        out_valid_r <= push_s;
        if (push_s) begin
          out_data_r <= in_data;
        end
      end
    end else if (push_s) begin
      skid_data_r  <= in_data;
      skid_valid_r <= 1'b1;
    end
  end

endmodule

// File: rtl/axi2lbus_burst_bridge.sv
// lbus to AXI3 master bridge: one INCR burst of 1..MaxBlen beats in flight at a time.
// Define AXI2LBUS_RESP_ERR_EN to add axi_bresp/axi_rresp inputs and a sticky bus_erro output.
module axi2lbus_burst_bridge
  import axi2lbus_burst_bridge_pkg::*;
#(
  parameter int  AddrW   = 32,
  parameter int  DataW   = 32,
  parameter int  IdW     = 2,
  parameter int  AxiIdW  = 4,
  parameter int  AxiId   = 0,
  parameter int  MaxBlen = 16,
  localparam int StrbW   = DataW / 8,
  localparam int BlenW   = $clog2(MaxBlen) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bus_req,
  input  logic              bus_we,
  input  logic [IdW-1:0]    bus_id,
  input  logic [AddrW-1:0]  bus_addr,
  input  logic [BlenW-1:0]  bus_blen,
  output logic              bus_acko,
  output logic              bus_busyo,
  input  logic [DataW-1:0]  bus_wdata,
  input  logic [StrbW-1:0]  bus_wstrb,
  input  logic              bus_wvalid,
  output logic              bus_wreadyo,
  output logic [DataW-1:0]  bus_rdatao,
  output logic              bus_rlasto,
  output logic              bus_rvalido,
  input  logic              bus_rready,
  output logic [IdW-1:0]    bus_ido,
  output logic              bus_doneo,
`ifdef AXI2LBUS_RESP_ERR_EN
  output logic              bus_erro,
  input  logic [1:0]        axi_bresp,
  input  logic [1:0]        axi_rresp,
`endif
  output logic [AxiIdW-1:0] axi_awido,
  output logic [AddrW-1:0]  axi_awaddro,
  output logic [3:0]        axi_awleno,
  output logic [2:0]        axi_awsizeo,
  output logic [1:0]        axi_awbursto,
  output logic              axi_awvalido,
  input  logic              axi_awready,
  output logic [DataW-1:0]  axi_wdatao,
  output logic [StrbW-1:0]  axi_wstrbo,
  output logic              axi_wlasto,
  output logic              axi_wvalido,
  input  logic              axi_wready,
  input  logic              axi_bvalid,
  input  logic [AxiIdW-1:0] axi_bid,
  output logic              axi_breadyo,
  output logic [AxiIdW-1:0] axi_arido,
  output logic [AddrW-1:0]  axi_araddro,
  output logic [3:0]        axi_arleno,
  output logic [2:0]        axi_arsizeo,
  output logic [1:0]        axi_arbursto,
  output logic              axi_arvalido,
  input  logic              axi_arready,
  input  logic [DataW-1:0]  axi_rdata,
  input  logic              axi_rlast,
  input  logic [AxiIdW-1:0] axi_rid,
  input  logic              axi_rvalid,
  output logic              axi_rreadyo
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_AR   = 3'd1,
    S_RD_DATA = 3'd2,
    S_RD_DONE = 3'd3,
    S_WR      = 3'd4,
    S_WR_RESP = 3'd5
  } state_t;

  state_t           state_r;
  logic [IdW-1:0]   id_r;
  logic [AddrW-1:0] addr_r;
  logic [BlenW-1:0] blen_r;
  logic [BlenW-1:0] beat_cnt_r;
  logic             aw_valid_r;
  logic             ar_valid_r;
  logic             aw_done_r;
  logic             w_done_r;
  logic             busy_r;
  logic             done_r;

  logic             accept_s;
  logic             aw_hs_s;
  logic             w_hs_s;
  logic             w_last_hs_s;
  logic             ar_hs_s;
  logic             r_hs_s;
  logic             b_hs_s;
  logic             rd_push_s;
  logic             skid_ready_s;
  logic             skid_empty_s;
  logic [DataW:0]   skid_out_s;

  // done_r blocks accept so a new request is taken only the cycle after the done pulse.
  assign accept_s    = (state_r == S_IDLE) && !done_r && bus_req;
  assign aw_hs_s     = aw_valid_r && axi_awready;
  assign w_hs_s      = axi_wvalido && axi_wready;
  assign w_last_hs_s = w_hs_s && (beat_cnt_r == blen_r);
  assign ar_hs_s     = ar_valid_r && axi_arready;
  assign r_hs_s      = axi_rvalid && axi_rreadyo;
  assign b_hs_s      = axi_bvalid && axi_breadyo;
  assign rd_push_s   = axi_rvalid && (state_r == S_RD_DATA);

  assign bus_acko  = accept_s;
  assign bus_busyo = busy_r;
  assign bus_doneo = done_r;
  assign bus_ido   = id_r;

  assign axi_awido    = AxiIdW'(AxiId);
  assign axi_awaddro  = addr_r;
  assign axi_awleno   = 4'(blen_r);
  assign axi_awsizeo  = size_from_width(DataW);
  assign axi_awbursto = BST_INCR;
  assign axi_awvalido = aw_valid_r;

  assign axi_wdatao  = bus_wdata;
  assign axi_wstrbo  = bus_wstrb;
  assign axi_wlasto  = (state_r == S_WR) && (beat_cnt_r == blen_r);
  assign axi_wvalido = (state_r == S_WR) && !w_done_r && bus_wvalid;
  assign bus_wreadyo = (state_r == S_WR) && !w_done_r && axi_wready;
  assign axi_breadyo = (state_r == S_WR_RESP);

  assign axi_arido    = AxiIdW'(AxiId);
  assign axi_araddro  = addr_r;
  assign axi_arleno   = 4'(blen_r);
  assign axi_arsizeo  = size_from_width(DataW);
  assign axi_arbursto = BST_INCR;
  assign axi_arvalido = ar_valid_r;
  assign axi_rreadyo  = (state_r == S_RD_DATA) && skid_ready_s;

  assign {bus_rlasto, bus_rdatao} = skid_out_s;

  lbus_skid_buf #(
    .W (DataW + 1)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (rd_push_s),
    .in_ready  (skid_ready_s),
    .in_data   ({axi_rlast, axi_rdata}),
    .out_valid (bus_rvalido),
    .out_ready (bus_rready),
    .out_data  (skid_out_s),
    .empty     (skid_empty_s)
  );

  // Transaction FSM: request latch, AXI address/response handshakes and completion pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= S_IDLE;
      id_r       <= '0;
      addr_r     <= '0;
      blen_r     <= '0;
      beat_cnt_r <= '0;
      aw_valid_r <= 1'b0;
      ar_valid_r <= 1'b0;
      aw_done_r  <= 1'b0;
      w_done_r   <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            id_r       <= bus_id;
            addr_r     <= bus_addr;
            blen_r     <= bus_blen;
            beat_cnt_r <= '0;
            aw_done_r  <= 1'b0;
            w_done_r   <= 1'b0;
            busy_r     <= 1'b1;
            if (bus_we) begin
              aw_valid_r <= 1'b1;
              state_r    <= S_WR;
            end else begin
              ar_valid_r <= 1'b1;
              state_r    <= S_RD_AR;
            end
          end
        end
        S_RD_AR: begin
          if (ar_hs_s) begin
            ar_valid_r <= 1'b0;
            state_r    <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (r_hs_s) begin
            beat_cnt_r <= beat_cnt_r + BlenW'(1);
            if (axi_rlast) begin
              state_r <= S_RD_DONE;
            end
          end
        end
        S_RD_DONE: begin
          if (skid_empty_s) begin
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= S_IDLE;
          end
        end
        S_WR: begin
          if (aw_hs_s) begin
            aw_valid_r <= 1'b0;
            aw_done_r  <= 1'b1;
          end
          if (w_hs_s) begin
            beat_cnt_r <= beat_cnt_r + BlenW'(1);
          end
          if (w_last_hs_s) begin
            w_done_r <= 1'b1;
          end
          // Address and last data beat may complete in either order or together.
          if ((aw_done_r || aw_hs_s) && (w_done_r || w_last_hs_s)) begin
            state_r <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (b_hs_s) begin
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= S_IDLE;
          end
        end
        default: begin
          aw_valid_r <= 1'b0;
          ar_valid_r <= 1'b0;
          busy_r     <= 1'b0;
          state_r    <= S_IDLE;
        end
      endcase
    end
  end

`ifdef AXI2LBUS_RESP_ERR_EN
  logic err_r;

  // Sticky per-transaction error flag, cleared when the next request is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_r <= 1'b0;
    end else if (accept_s) begin
      err_r <= 1'b0;
    end else if ((r_hs_s && resp_is_err(axi_rresp)) || (b_hs_s && resp_is_err(axi_bresp))) begin
      err_r <= 1'b1;
    end
  end

  assign bus_erro = err_r;
`endif

  axi2lbus_burst_bridge_chk #(
    .BlenW  (BlenW),
    .StrbW  (StrbW),
    .AxiIdW (AxiIdW),
    .AxiId  (AxiId)
  ) u_chk (
    .clk      (clk),
    .reset    (reset),
    .accept   (accept_s),
    .addr_lo  (bus_addr[11:0]),
    .req_blen (bus_blen),
    .blen     (blen_r),
    .beat_cnt (beat_cnt_r),
    .r_hs     (r_hs_s),
    .r_last   (axi_rlast),
    .rid      (axi_rid),
    .b_hs     (b_hs_s),
    .bid      (axi_bid)
  );

endmodule
